// File: rtl/data_combine_n.sv
// data_combine_n: lane-to-serial combiner placed after the parallel sub-FFT stage.
// Lane 0 streams straight through one register stage. Lanes 1..NUM_LANES-1 are
// buffered in per-lane dual-port RAMs and drained back-to-back after lane 0, with
// sof/eof framing and a sticky overrun flag.
// Optional build macro DATA_COMBINE_REVERSE_EN: buffered lanes are read in
// descending address order (SUB_POINT-1..0). out_cnt still counts ascending.
module data_combine_n #(
  parameter int DATA_W    = 16,
  parameter int NUM_LANES = 4,
  parameter int SUB_POINT = 512,
  localparam int ADDR_W   = $clog2(SUB_POINT),
  localparam int CNT_W    = $clog2(NUM_LANES * SUB_POINT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [CNT_W-1:0]              out_cnt,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic                          overrun
);

  localparam int TOTAL   = NUM_LANES * SUB_POINT;
  localparam int NBUF    = NUM_LANES - 1;
  localparam int SEL_W   = (NBUF > 1) ? $clog2(NBUF) : 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(SUB_POINT - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  CNT_PENULT  = CNT_W'(TOTAL - 2);
  localparam logic [SEL_W-1:0]  SEL_LAST    = SEL_W'(NBUF - 1);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DRAIN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   rd_cnt;     // drain position within the current buffered lane
  logic [SEL_W-1:0]    rd_sel;     // buffered lane being read (0 selects RAM of lane 1)
  logic [SEL_W-1:0]    q_sel;      // buffered lane whose data sits in the RAM output regs
  logic [ADDR_W-1:0]   rd_addr;
  logic                accept;
  logic [NBUF*DATA_W-1:0] rd_all;  // registered read data of every buffered lane
  logic [DATA_W-1:0]   sel_data;

  // A beat is taken anywhere in PASS, but only a frame start (addr 0) in IDLE
  always_comb begin
    accept = in_valid && ((state == PASS) || ((state == IDLE) && (in_addr == '0)));
  end

  // Physical read address: ascending, or mirrored for reversed read order
  always_comb begin
`ifdef DATA_COMBINE_REVERSE_EN
    rd_addr = ~rd_cnt;
`else
    rd_addr = rd_cnt;
`endif
  end

  // Pick the buffered lane whose read data is currently registered
  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NBUF; j++) begin
      if (q_sel == SEL_W'(j)) begin
        sel_data = rd_all[j*DATA_W +: DATA_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NUM_LANES; gi++) begin : g_lane_ram
      logic [DATA_W-1:0] mem [SUB_POINT];
      logic [DATA_W-1:0] wr_data;
      logic [DATA_W-1:0] rd_q;

      assign wr_data = in_data[gi*DATA_W +: DATA_W];
      assign rd_all[(gi-1)*DATA_W +: DATA_W] = rd_q;

      // Lane buffer with registered read; a same-address write is forwarded so
      // the reversed drain can read the final sample in the cycle it is written
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[in_addr] <= wr_data;
        end
        if (accept && (in_addr == rd_addr)) begin
          rd_q <= wr_data;
        end else begin
          rd_q <= mem[rd_addr];
        end
      end
    end
  endgenerate

  // Frame sequencer, read pointer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      rd_sel    <= '0;
      q_sel     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      q_sel     <= rd_sel;

      if (in_valid && (state == DRAIN)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE, PASS: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data[DATA_W-1:0];
            out_cnt   <= {{(CNT_W-ADDR_W){1'b0}}, in_addr};
            out_sof   <= (in_addr == '0);
            if (in_addr == ADDR_LAST) begin
              // The RAM read of the first drain address happens on this edge
              state  <= DRAIN;
              rd_cnt <= ADDR_W'(1);
            end else begin
              state <= PASS;
            end
          end
        end

        DRAIN: begin
          out_valid <= 1'b1;
          out_data  <= sel_data;
          out_cnt   <= (out_cnt == CNT_LAST) ? '0 : out_cnt + 1'b1;
          out_eof   <= (out_cnt == CNT_PENULT);
          if (out_cnt == CNT_PENULT) begin
            state  <= IDLE;
            rd_cnt <= '0;
            rd_sel <= '0;
          end else if (rd_cnt == ADDR_LAST) begin
            rd_cnt <= '0;
            rd_sel <= (rd_sel == SEL_LAST) ? '0 : rd_sel + 1'b1;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
